// File: rtl/vga_layer_regs_if.sv
// Wishbone-style config bus between the CPU and the VGA layer register file.
// The master drives the request; the slave answers with read data, ack and stall.
interface vga_layer_regs_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [9:2]  adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        ack;
  logic        stall;

  modport master (output cyc, stb, we, sel, adr, wdat, input  rdat, ack, stall);
  modport slave  (input  cyc, stb, we, sel, adr, wdat, output rdat, ack, stall);
endinterface

// File: rtl/vga_layer_regs.sv
// Config register file for the multi-layer VGA engine: per-layer shadow registers
// that commit to the active outputs at vblank, plus a vblank interrupt and frame counter.
module vga_layer_regs #(
  parameter int          NLAYERS      = 2,
  parameter logic [31:0] VGA_MEMBASE  = 32'h0,
  parameter logic [31:0] LAYER_STRIDE = 32'h40000,
  parameter logic [31:0] DEFAULT_MODE = 32'h02
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  vga_layer_regs_if.slave        inbus,
  input  logic                   vblank_i,
  output logic [32*NLAYERS-1:0]  base_o,
  output logic [32*NLAYERS-1:0]  mode_o,
  output logic [32*NLAYERS-1:0]  cursorpos_o,
  output logic [24*NLAYERS-1:0]  cursorcolor_o,
  output logic                   irq_o
);
  localparam int LW = (NLAYERS > 1) ? $clog2(NLAYERS) : 1;

  typedef enum logic {S_IDLE, S_ACK} state_t;
  state_t state, state_nxt;

  logic [31:0] sh_base [NLAYERS];
  logic [31:0] sh_mode [NLAYERS];
  logic [31:0] sh_cpos [NLAYERS];
  logic [23:0] sh_ccol [NLAYERS];
  logic [31:0] act_base[NLAYERS];
  logic [31:0] act_mode[NLAYERS];
  logic [31:0] act_cpos[NLAYERS];
  logic [23:0] act_ccol[NLAYERS];

  logic        vbl, irqen, pending, autocommit;
  logic [15:0] frame_cnt;

  logic [5:0]    lsel;
  logic [1:0]    rsel;
  logic [LW-1:0] lidx;
  logic          layer_hit, global_hit, access, wr_en, do_commit;
  logic [31:0]   wr_merge, rd_data;

  function automatic logic [31:0] reset_base(input int l);
    return VGA_MEMBASE + LAYER_STRIDE * 32'(l);
  endfunction

  function automatic logic [31:0] reset_mode(input int l);
    return (l == 0) ? DEFAULT_MODE : 32'h0;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] sel);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) res[8*k +: 8] = sel[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
    return res;
  endfunction

  assign lsel       = inbus.adr[9:4];
  assign rsel       = inbus.adr[3:2];
  assign lidx       = lsel[LW-1:0];
  assign layer_hit  = int'(lsel) < NLAYERS;
  assign global_hit = (lsel == 6'd63);
  assign access     = (state == S_IDLE) && inbus.cyc && inbus.stb;
  assign wr_en      = access && inbus.we;
  assign do_commit  = vblank_i && (pending || autocommit);
  assign irq_o      = vbl & irqen;

  // Bus FSM: every access takes one decode cycle and one ack cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (inbus.cyc && inbus.stb) state_nxt = S_ACK;
      S_ACK:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    inbus.ack   = 1'b0;
    inbus.stall = 1'b0;
    if (state == S_ACK) begin
      inbus.ack   = 1'b1;
      inbus.stall = 1'b1;
    end
  end

  // NOTE: give every combinational output a default first so no path infers a latch.
  always_comb begin
    rd_data  = '0;
    wr_merge = '0;
    if (layer_hit) begin
      case (rsel)
        2'd0: rd_data = sh_base[lidx];
        2'd1: rd_data = sh_mode[lidx];
        2'd2: rd_data = sh_cpos[lidx];
        default: rd_data = {8'h0, sh_ccol[lidx]};
      endcase
    end else if (global_hit) begin
      case (rsel)
        2'd0: rd_data = {31'b0, vbl};
        2'd1: rd_data = {31'b0, irqen};
        2'd2: rd_data = {16'b0, frame_cnt};
        default: rd_data = {30'b0, autocommit, pending};
      endcase
    end
    wr_merge = byte_merge(rd_data, inbus.wdat, inbus.sel);
  end

  // Commit copies the pre-write shadow, so a same-cycle shadow write lands next frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: these arrays are flops with defined power-on values, so each entry is reset explicitly.
      for (int l = 0; l < NLAYERS; l++) begin
        sh_base[l]  <= reset_base(l);
        sh_mode[l]  <= reset_mode(l);
        sh_cpos[l]  <= '0;
        sh_ccol[l]  <= 24'ha0a0a0;
        act_base[l] <= reset_base(l);
        act_mode[l] <= reset_mode(l);
        act_cpos[l] <= '0;
        act_ccol[l] <= 24'ha0a0a0;
      end
    end else begin
      if (do_commit) begin
        for (int l = 0; l < NLAYERS; l++) begin
          act_base[l] <= sh_base[l];
          act_mode[l] <= sh_mode[l];
          act_cpos[l] <= sh_cpos[l];
          act_ccol[l] <= sh_ccol[l];
        end
      end
      if (wr_en && layer_hit) begin
        case (rsel)
          2'd0: sh_base[lidx] <= wr_merge;
          2'd1: sh_mode[lidx] <= wr_merge;
          2'd2: sh_cpos[lidx] <= wr_merge;
          default: sh_ccol[lidx] <= wr_merge[23:0];
        endcase
      end
    end
  end

  // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vbl        <= 1'b0;
      irqen      <= 1'b0;
      pending    <= 1'b0;
      autocommit <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      if (vblank_i)
        vbl <= 1'b1;
      else if (wr_en && global_hit && rsel == 2'd0 && inbus.sel[0] && inbus.wdat[0])
        vbl <= 1'b0;
      if (wr_en && global_hit && rsel == 2'd1 && inbus.sel[0])
        irqen <= inbus.wdat[0];
      if (wr_en && global_hit && rsel == 2'd3 && inbus.sel[0]) begin
        autocommit <= inbus.wdat[1];
        if (inbus.wdat[0]) pending <= 1'b1;
        else if (do_commit) pending <= 1'b0;
      end else if (do_commit) begin
        pending <= 1'b0;
      end
      if (vblank_i) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       inbus.rdat <= '0;
    else if (access) inbus.rdat <= rd_data;
  end

  for (genvar l = 0; l < NLAYERS; l++) begin : g_out
    assign base_o[32*l +: 32]        = act_base[l];
    assign mode_o[32*l +: 32]        = act_mode[l];
    assign cursorpos_o[32*l +: 32]   = act_cpos[l];
    assign cursorcolor_o[24*l +: 24] = act_ccol[l];
  end
endmodule

// File: tb/tb_vga_layer_regs.sv
// Self-checking bench for vga_layer_regs: directed scenarios plus random bus traffic
// compared against a register-level reference model.
module tb_vga_layer_regs;
  localparam int          NL      = 2;
  localparam logic [31:0] MEMBASE = 32'h1000_0000;
  localparam logic [31:0] STRIDE  = 32'h0004_0000;
  localparam logic [31:0] DMODE   = 32'h0000_0002;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic vblank_i = 1'b0;
  logic [32*NL-1:0] base_o, mode_o, cursorpos_o;
  logic [24*NL-1:0] cursorcolor_o;
  logic irq_o;

  vga_layer_regs_if inbus();

  vga_layer_regs #(
    .NLAYERS(NL), .VGA_MEMBASE(MEMBASE), .LAYER_STRIDE(STRIDE), .DEFAULT_MODE(DMODE)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .inbus(inbus.slave), .vblank_i(vblank_i),
    .base_o(base_o), .mode_o(mode_o), .cursorpos_o(cursorpos_o),
    .cursorcolor_o(cursorcolor_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model: shadow/active register sets and global state.
  logic [31:0] s_base[NL], s_mode[NL], s_cpos[NL], a_base[NL], a_mode[NL], a_cpos[NL];
  logic [23:0] s_ccol[NL], a_ccol[NL];
  logic m_vbl, m_irqen, m_pend, m_auto;
  int   m_frame;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int l = 0; l < NL; l++) begin
      s_base[l] = MEMBASE + STRIDE * l;
      s_mode[l] = (l == 0) ? DMODE : 32'h0;
      s_cpos[l] = 32'h0;
      s_ccol[l] = 24'ha0a0a0;
      a_base[l] = s_base[l];
      a_mode[l] = s_mode[l];
      a_cpos[l] = s_cpos[l];
      a_ccol[l] = s_ccol[l];
    end
    m_vbl = 0; m_irqen = 0; m_pend = 0; m_auto = 0; m_frame = 0;
  endfunction

  function automatic logic [31:0] m_bytes(input logic [31:0] old_v, input logic [31:0] d,
                                          input logic [3:0] sel);
    logic [31:0] r = old_v;
    for (int k = 0; k < 4; k++) if (sel[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [9:0] a);
    int l = int'(a[9:4]);
    int r = int'(a[3:2]);
    logic [31:0] fr = m_frame;
    if (l < NL) begin
      if (r == 0) return s_base[l];
      if (r == 1) return s_mode[l];
      if (r == 2) return s_cpos[l];
      return {8'h0, s_ccol[l]};
    end
    if (l == 63) begin
      if (r == 0) return {31'b0, m_vbl};
      if (r == 1) return {31'b0, m_irqen};
      if (r == 2) return {16'b0, fr[15:0]};
      return {30'b0, m_auto, m_pend};
    end
    return 32'h0;
  endfunction

  // One clock edge of the model: commit decision on old state, then the write, then vblank status.
  function automatic void m_step(input logic we, input logic [9:0] a, input logic [31:0] d,
                                 input logic [3:0] sel, input logic vbl);
    int l = int'(a[9:4]);
    int r = int'(a[3:2]);
    logic commit = vbl && (m_pend || m_auto);
    logic [31:0] cc;
    if (commit) begin
      a_base = s_base; a_mode = s_mode; a_cpos = s_cpos; a_ccol = s_ccol;
      m_pend = 0;
    end
    if (we && l < NL) begin
      if (r == 0) s_base[l] = m_bytes(s_base[l], d, sel);
      if (r == 1) s_mode[l] = m_bytes(s_mode[l], d, sel);
      if (r == 2) s_cpos[l] = m_bytes(s_cpos[l], d, sel);
      if (r == 3) begin
        cc = m_bytes({8'h0, s_ccol[l]}, d, sel);
        s_ccol[l] = cc[23:0];
      end
    end else if (we && l == 63 && sel[0]) begin
      if (r == 0 && d[0]) m_vbl = 0;
      if (r == 1) m_irqen = d[0];
      if (r == 3) begin
        m_auto = d[1];
        if (d[0]) m_pend = 1;
      end
    end
    if (vbl) begin
      m_vbl = 1;
      m_frame = (m_frame + 1) % 65536;
    end
  endfunction

  task automatic chk_outs(input string tag);
    logic [32*NL-1:0] eb, em, ep;
    logic [24*NL-1:0] ec;
    for (int l = 0; l < NL; l++) begin
      eb[32*l +: 32] = a_base[l];
      em[32*l +: 32] = a_mode[l];
      ep[32*l +: 32] = a_cpos[l];
      ec[24*l +: 24] = a_ccol[l];
    end
    check({tag, ".base_o"}, base_o, eb);
    check({tag, ".mode_o"}, mode_o, em);
    check({tag, ".cursorpos_o"}, cursorpos_o, ep);
    check({tag, ".cursorcolor_o"}, cursorcolor_o, ec);
    check({tag, ".irq_o"}, irq_o, m_vbl & m_irqen);
  endtask

  task automatic bus(input logic we, input logic [9:0] a, input logic [31:0] d,
                     input logic [3:0] sel, input logic vbl, output logic [31:0] rd);
    logic [31:0] exp;
    @(negedge clk_i);
    inbus.cyc = 1; inbus.stb = 1; inbus.we = we; inbus.adr = a[9:2];
    inbus.wdat = d; inbus.sel = sel; vblank_i = vbl;
    exp = m_read(a);
    @(posedge clk_i); #1;
    inbus.cyc = 0; inbus.stb = 0; vblank_i = 0;
    m_step(we, a, d, sel, vbl);
    check("ack", inbus.ack, 1'b1);
    check("stall", inbus.stall, 1'b1);
    rd = inbus.rdat;
    if (!we) check($sformatf("rd@%03h", a), rd, exp);
    @(posedge clk_i); #1;
    check("ack_clear", inbus.ack, 1'b0);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] dummy;
    bus(1'b1, a, d, sel, 1'b0, dummy);
  endtask

  task automatic rd_chk(input logic [9:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    bus(1'b0, a, 32'h0, 4'h0, 1'b0, v);
    check(tag, v, exp);
  endtask

  task automatic pulse_vblank();
    @(negedge clk_i);
    vblank_i = 1;
    #1 chk_outs("pre_vbl");
    @(posedge clk_i); #1;
    vblank_i = 0;
    m_step(1'b0, 10'h0, 32'h0, 4'h0, 1'b1);
    chk_outs("post_vbl");
  endtask

  task automatic do_reset();
    inbus.cyc = 0; inbus.stb = 0; inbus.we = 0; inbus.sel = 0; inbus.adr = 0; inbus.wdat = 0;
    vblank_i = 0;
    rst_i = 1;
    m_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 0;
  endtask

  initial begin
    logic [31:0] v;
    int acks, stalls;

    do_reset();
    check("rst.ack", inbus.ack, 1'b0);
    check("rst.stall", inbus.stall, 1'b0);
    check("rst.rdat", inbus.rdat, 32'h0);
    chk_outs("rst");
    check("rst.base1", base_o[63:32], MEMBASE + STRIDE);
    rd_chk(10'h000, MEMBASE, "t1.base0");
    rd_chk(10'h004, 32'h02, "t1.mode0");
    rd_chk(10'h00C, 32'h00a0a0a0, "t1.ccol0");

    // Partial-byte write to layer 1 base stays in the shadow until a commit at vblank.
    wr(10'h010, 32'h1234_5678, 4'b0011);
    rd_chk(10'h010, 32'h1004_5678, "t2.shadow");
    check("t2.active_hold", base_o[63:32], MEMBASE + STRIDE);
    pulse_vblank();
    check("t2.no_commit", base_o[63:32], MEMBASE + STRIDE);
    wr(10'h3FC, 32'h1, 4'hF);
    pulse_vblank();
    check("t2.committed", base_o[63:32], 32'h1004_5678);

    // Commit request colliding with vblank stays pending for the next frame.
    wr(10'h000, 32'hCAFE_0000, 4'hF);
    wr(10'h3FC, 32'h1, 4'hF);
    wr(10'h004, 32'h0000_0055, 4'h1);
    bus(1'b1, 10'h3FC, 32'h1, 4'hF, 1'b1, v);
    chk_outs("t3.first");
    check("t3.base0", base_o[31:0], 32'hCAFE_0000);
    rd_chk(10'h3FC, 32'h1, "t3.pending");
    pulse_vblank();
    rd_chk(10'h3FC, 32'h0, "t3.cleared");

    // vblank interrupt, frame counter, and set-beats-clear on status.
    wr(10'h3F4, 32'h1, 4'hF);
    pulse_vblank();
    check("t4.irq", irq_o, 1'b1);
    bus(1'b1, 10'h3F0, 32'h1, 4'hF, 1'b1, v);
    rd_chk(10'h3F0, 32'h1, "t4.vbl_set_wins");
    wr(10'h3F0, 32'h1, 4'hF);
    rd_chk(10'h3F0, 32'h0, "t4.vbl_cleared");
    check("t4.irq_low", irq_o, 1'b0);

    // Random traffic against the model.
    for (int it = 0; it < 300; it++) begin
      int kind = $urandom_range(0, 9);
      logic [5:0] l;
      logic [9:0] a;
      if (kind < 6)       l = 6'($urandom_range(0, NL - 1));
      else if (kind == 6) l = 6'($urandom_range(NL, 62));
      else                l = 6'd63;
      a = {l, 2'($urandom_range(0, 3)), 2'b00};
      bus(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          ($urandom_range(0, 5) == 0), v);
      if ($urandom_range(0, 3) == 0) pulse_vblank();
      else chk_outs("rand");
    end

    // Frame counter wrap after 65536 vblanks; unmapped address reads zero.
    do_reset();
    @(negedge clk_i);
    vblank_i = 1;
    repeat (65536) @(posedge clk_i);
    #1 vblank_i = 0;
    for (int i = 0; i < 65536; i++) m_step(1'b0, 10'h0, 32'h0, 4'h0, 1'b1);
    rd_chk(10'h3F8, 32'h0, "t5.frame_wrap");
    rd_chk(10'h3E0, 32'h0, "t5.unmapped");
    wr(10'h3E0, 32'hFFFF_FFFF, 4'hF);
    chk_outs("t5.after_unmapped_wr");

    // Back-to-back strobes: one ack per two cycles, stall in each ack cycle.
    @(negedge clk_i);
    inbus.cyc = 1; inbus.stb = 1; inbus.we = 0; inbus.adr = 8'h00;
    acks = 0; stalls = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk_i); #1;
      if (inbus.ack) acks++;
      if (inbus.stall && inbus.ack) stalls++;
    end
    inbus.cyc = 0; inbus.stb = 0;
    check("t6.acks", acks, 3);
    check("t6.stalls", stalls, 3);
    @(posedge clk_i); #1;
    check("t6.idle_ack", inbus.ack, 1'b0);

    // Reset in the ack cycle drops the access and restores reset values.
    @(negedge clk_i);
    inbus.cyc = 1; inbus.stb = 1; inbus.we = 1; inbus.adr = 8'h00;
    inbus.wdat = 32'hDEAD_BEEF; inbus.sel = 4'hF;
    @(posedge clk_i); #1;
    check("t6.ack_before_rst", inbus.ack, 1'b1);
    rst_i = 1;
    #1;
    check("t6.ack_in_rst", inbus.ack, 1'b0);
    inbus.cyc = 0; inbus.stb = 0; inbus.we = 0;
    m_reset();
    @(negedge clk_i);
    rst_i = 0;
    @(posedge clk_i); #1;
    check("t6.ack_after_rst", inbus.ack, 1'b0);
    chk_outs("t6.rst");
    rd_chk(10'h000, MEMBASE, "t6.base0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
